// File: rtl/ps2_scancode_receiver.sv
// PS/2 device-to-host receiver: synchronizes and deglitches the raw PS/2
// lines, decodes 11-bit frames (start, 8 data LSB first, odd parity, stop)
// and emits each correctly received byte with a one-cycle strobe.
module ps2_scancode_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       scancode_done,
    output logic       frame_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Input conditioning registers
    logic                  clk_s1_q, clk_s2_q;
    logic                  data_s1_q, data_s2_q;
    logic [FILTER_LEN-1:0] filt_sr_q;
    logic                  filt_clk_q, filt_clk_d;
    logic                  filt_prev_q;
    logic                  fall_s;

    // Frame decode registers
    state_t                state_q, state_d;
    logic [3:0]            bitcnt_q, bitcnt_d;
    logic [7:0]            shreg_q, shreg_d;
    logic                  parity_q, parity_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [7:0]            scancode_q, scancode_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    // Two-flop synchronizers for both raw lines (idle high)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
        end else begin
            clk_s1_q  <= ps2_clk;
            clk_s2_q  <= clk_s1_q;
            data_s1_q <= ps2_data;
            data_s2_q <= data_s1_q;
        end
    end

    // Filtered clock only changes when every tap of the shift register agrees
    always_comb begin
        filt_clk_d = filt_clk_q;
        if (&filt_sr_q) begin
            filt_clk_d = 1'b1;
        end else if (~|filt_sr_q) begin
            filt_clk_d = 1'b0;
        end else begin
            filt_clk_d = filt_clk_q;
        end
    end

    // Deglitch shift register, filtered clock and its previous value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_sr_q   <= {FILTER_LEN{1'b1}};
            filt_clk_q  <= 1'b1;
            filt_prev_q <= 1'b1;
        end else begin
            filt_sr_q   <= {filt_sr_q[FILTER_LEN-2:0], clk_s2_q};
            filt_clk_q  <= filt_clk_d;
            filt_prev_q <= filt_clk_q;
        end
    end

    // Single-cycle pulse on each falling edge of the filtered clock
    assign fall_s = filt_prev_q & ~filt_clk_q;

    // Next-state, bit capture, timeout and output strobes
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        parity_d   = parity_q;
        tmo_d      = tmo_q;
        scancode_d = scancode_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        if (state_q == ST_IDLE) begin
            tmo_d = {TW{1'b0}};
        end else if (fall_s) begin
            tmo_d = {TW{1'b0}};
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (fall_s && (data_s2_q == 1'b0)) begin
                    state_d  = ST_DATA;
                    bitcnt_d = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (fall_s) begin
                    shreg_d  = {data_s2_q, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (fall_s) begin
                    parity_d = data_s2_q;
                    state_d  = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (fall_s) begin
                    if ((data_s2_q == 1'b1) && ((^{shreg_q, parity_q}) == 1'b1)) begin
                        scancode_d = shreg_q;
                        done_d     = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A stalled partial frame is dropped; a fall in this cycle wins
        if ((state_q != ST_IDLE) && !fall_s && (tmo_q == TMO_LAST)) begin
            state_d = ST_IDLE;
            tmo_d   = {TW{1'b0}};
            err_d   = 1'b1;
            done_d  = 1'b0;
        end else begin
            err_d = err_d;
        end
    end

    // Decoder state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= 4'd0;
            shreg_q    <= 8'h00;
            parity_q   <= 1'b0;
            tmo_q      <= {TW{1'b0}};
            scancode_q <= 8'h00;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            parity_q   <= parity_d;
            tmo_q      <= tmo_d;
            scancode_q <= scancode_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign scancode      = scancode_q;
    assign scancode_done = done_q;
    assign frame_error   = err_q;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Randomized bench for ps2_scancode_receiver: frames are built bit by bit on
// the wire and the expected outcome of each is derived from the frame rules
// (start 0, odd parity over data+parity, stop 1) by a small model.
module tb_ps2_scancode_receiver;

    localparam int FILT = 8;
    localparam int TMO  = 400;
    localparam int HALF = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scancode;
    logic       scancode_done;
    logic       frame_error;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    logic [7:0] exp_code = 8'h00;

    ps2_scancode_receiver #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .scancode      (scancode),
        .scancode_done (scancode_done),
        .frame_error   (frame_error)
    );

    always #5 clk = ~clk;

    // Count strobe cycles, sampled away from the active edge
    always @(negedge clk) begin
        if (scancode_done) done_cnt <= done_cnt + 1;
        if (frame_error)   err_cnt  <= err_cnt + 1;
        if (scancode_done && frame_error) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Drive the first nbits of a frame; optional short low glitch during a high phase
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input int nbits, input int glitch_at);
        logic [10:0] bits;
        bits = {stp, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            if (i == glitch_at) begin
                wait_clk(HALF / 2);
                ps2_clk = 1'b0;
                wait_clk(3);
                ps2_clk = 1'b1;
                wait_clk(HALF - HALF / 2 - 3);
            end else begin
                wait_clk(HALF);
            end
            ps2_clk = 1'b0;
            wait_clk(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    // kind: 0 good, 1 bad parity, 2 bad stop. Model decides outcome from frame rules.
    task automatic run_frame(input string tag, input logic [7:0] d, input int kind,
                             input int glitch_at, input int gap);
        int d0, e0, ones;
        logic par, stp, ok;
        par = ~^d;
        if (kind == 1) par = ~par;
        stp = (kind == 2) ? 1'b0 : 1'b1;
        ones = $countones(d) + int'(par);
        ok = (stp == 1'b1) && ((ones % 2) == 1);
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(d, par, stp, 11, glitch_at);
        wait_clk(gap);
        if (ok) exp_code = d;
        @(negedge clk);
        check({tag, "_done"}, done_cnt - d0, ok ? 1 : 0);
        check({tag, "_err"}, err_cnt - e0, ok ? 0 : 1);
        check({tag, "_code"}, {24'h0, scancode}, {24'h0, exp_code});
    endtask

    initial begin
        int d0, e0;
        wait_clk(3);
        @(negedge clk);
        check("rst_code", {24'h0, scancode}, 32'h0);
        check("rst_done", {31'h0, scancode_done}, 32'h0);
        check("rst_err", {31'h0, frame_error}, 32'h0);
        rst = 1'b0;
        wait_clk(20);

        // Directed cases
        run_frame("f1c", 8'h1C, 0, -1, 40);
        run_frame("bbf0", 8'hF0, 0, -1, 0);
        run_frame("bb1c", 8'h1C, 0, -1, 40);
        run_frame("badpar", 8'h1C, 1, -1, 40);
        run_frame("badstop", 8'h3A, 2, -1, 40);

        // Stalled frame: start + 4 data bits then silence past the timeout
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(8'h0F, 1'b0, 1'b1, 5, -1);
        wait_clk(TMO + 200);
        @(negedge clk);
        check("tmo_err", err_cnt - e0, 1);
        check("tmo_done", done_cnt - d0, 0);
        check("tmo_code", {24'h0, scancode}, {24'h0, exp_code});
        run_frame("after_tmo", 8'h12, 0, -1, 40);

        // Glitches in IDLE and mid-frame
        ps2_clk = 1'b0;
        wait_clk(3);
        ps2_clk = 1'b1;
        wait_clk(30);
        run_frame("glitch", 8'h59, 0, 4, 40);

        // Reset in the middle of a frame
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(8'hA5, 1'b1, 1'b1, 6, -1);
        wait_clk(5);
        rst = 1'b1;
        wait_clk(3);
        @(negedge clk);
        check("midrst_code", {24'h0, scancode}, 32'h0);
        check("midrst_done", done_cnt - d0, 0);
        check("midrst_err", err_cnt - e0, 0);
        exp_code = 8'h00;
        @(posedge clk);
        rst = 1'b0;
        wait_clk(20);
        run_frame("after_rst", 8'h14, 0, -1, 40);

        // Random frames, some corrupted, some back-to-back
        for (int i = 0; i < 24; i++) begin
            logic [7:0] d;
            int k, r;
            d = 8'($urandom_range(0, 255));
            r = int'($urandom_range(0, 9));
            k = (r < 6) ? 0 : ((r < 8) ? 1 : 2);
            run_frame("rand", d, k, -1, ($urandom_range(0, 1) == 0) ? 0 : 40);
        end

        check("never_both", both_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
